// File: rtl/ps2_mouse_pkg.sv
// Shared types and byte constants for the PS/2 mouse init controller.
// Holds the FSM state encoding, the command and response bytes, and the error codes.
package ps2_mouse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE  = 8'hF3;
    localparam logic [7:0] CMD_SET_RES   = 8'hE8;
    localparam logic [7:0] CMD_EN_STREAM = 8'hF4;

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID_STD = 8'h00;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_NAK     = 3'd2;
    localparam logic [2:0] ERR_BAT     = 3'd3;
    localparam logic [2:0] ERR_ID      = 3'd4;

    localparam logic [2:0] LAST_STEP = 3'd5;

endpackage

// File: rtl/ps2_timeout_timer.sv
// Watchdog for a single wait: cleared by clr, counts while en is high, saturates at TIMEOUT_CYC.
// expire is combinational and is asserted while enabled and the count has reached the limit.
module ps2_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LIMIT) begin
            count <= count + W'(1);
        end
    end

    assign expire = en && (count == LIMIT);

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse power-up sequencer: FF, F3+rate, E8+res, F4 with ACK/BAT/ID checks and retries.
// Owns the transceiver TX path until configuration succeeds, then passes it to stream_FSM.
module ps2_mouse_init_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [7:0]  SAMPLE_RATE = 8'd100,
    parameter logic [7:0]  RESOLUTION  = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    input  logic       tx_done_tick,
    input  logic       s_wr_ps2,
    input  logic [7:0] s_tx_data,
    output logic       wr_ps2,
    output logic [7:0] tx_data,
    output logic       s_rx_done_tick,
    output logic       busy,
    output logic       init_done,
    output logic       init_err,
    output logic [2:0] err_code
);

    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t        state;
    logic [2:0]    step;
    logic [RW-1:0] retry_q;
    logic          wr_int;
    logic [7:0]    tx_int;

    logic          in_wait;
    logic          wait_ev;
    logic          tmr_clr;
    logic          tmr_exp;
    logic          fail_vld;
    logic          fail_resend;
    logic [2:0]    fail_code;
    logic [2:0]    restart_step;

    function automatic logic [7:0] step_byte(input logic [2:0] s);
        case (s)
            3'd0:    step_byte = CMD_RESET;
            3'd1:    step_byte = CMD_SET_RATE;
            3'd2:    step_byte = SAMPLE_RATE;
            3'd3:    step_byte = CMD_SET_RES;
            3'd4:    step_byte = RESOLUTION;
            default: step_byte = CMD_EN_STREAM;
        endcase
    endfunction

    // Any strobe seen in a wait state always moves the FSM, so it also restarts the timer.
    assign in_wait = (state == ST_WAIT_TX) || (state == ST_WAIT_ACK) ||
                     (state == ST_WAIT_BAT) || (state == ST_WAIT_ID);
    assign wait_ev = (state == ST_WAIT_TX) ? tx_done_tick : rx_done_tick;
    assign tmr_clr = !in_wait || wait_ev;

    ps2_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (in_wait),
        .expire (tmr_exp)
    );

    // Classify retryable failures; a strobe in the same cycle as expiry takes priority.
    always_comb begin
        fail_vld    = 1'b0;
        fail_resend = 1'b0;
        fail_code   = err_code;
        case (state)
            ST_WAIT_ACK: begin
                if (rx_done_tick) begin
                    if (rx_data == RSP_RESEND) begin
                        fail_vld    = 1'b1;
                        fail_resend = 1'b1;
                    end else if (rx_data != RSP_ACK) begin
                        fail_vld  = 1'b1;
                        fail_code = ERR_NAK;
                    end
                end
            end
            ST_WAIT_BAT: begin
                if (rx_done_tick && rx_data != RSP_BAT_OK) begin
                    fail_vld  = 1'b1;
                    fail_code = ERR_BAT;
                end
            end
            default: ;
        endcase
        if (in_wait && !wait_ev && tmr_exp) begin
            fail_vld  = 1'b1;
            fail_code = ERR_TIMEOUT;
        end
    end

    assign restart_step = fail_resend ? step : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step      <= 3'd0;
            retry_q   <= '0;
            wr_int    <= 1'b0;
            tx_int    <= 8'h00;
            busy      <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            wr_int <= 1'b0;
            if (fail_vld) begin
                err_code <= fail_code;
                if (retry_q == RW'(MAX_RETRY)) begin
                    state    <= ST_ERROR;
                    busy     <= 1'b0;
                    init_err <= 1'b1;
                end else begin
                    retry_q <= retry_q + RW'(1);
                    step    <= restart_step;
                    state   <= ST_SEND;
                    wr_int  <= 1'b1;
                    tx_int  <= step_byte(restart_step);
                end
            end else begin
                case (state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (start) begin
                            state     <= ST_SEND;
                            step      <= 3'd0;
                            retry_q   <= '0;
                            err_code  <= ERR_NONE;
                            init_done <= 1'b0;
                            init_err  <= 1'b0;
                            busy      <= 1'b1;
                            wr_int    <= 1'b1;
                            tx_int    <= CMD_RESET;
                        end
                    end
                    ST_SEND: state <= ST_WAIT_TX;
                    ST_WAIT_TX: begin
                        if (tx_done_tick) state <= ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        if (rx_done_tick) begin
                            if (step == 3'd0) begin
                                state <= ST_WAIT_BAT;
                            end else if (step == LAST_STEP) begin
                                state     <= ST_DONE;
                                busy      <= 1'b0;
                                init_done <= 1'b1;
                            end else begin
                                step   <= step + 3'd1;
                                state  <= ST_SEND;
                                wr_int <= 1'b1;
                                tx_int <= step_byte(step + 3'd1);
                            end
                        end
                    end
                    ST_WAIT_BAT: begin
                        if (rx_done_tick) state <= ST_WAIT_ID;
                    end
                    ST_WAIT_ID: begin
                        if (rx_done_tick) begin
                            if (rx_data == RSP_ID_STD) begin
                                step   <= 3'd1;
                                state  <= ST_SEND;
                                wr_int <= 1'b1;
                                tx_int <= step_byte(3'd1);
                            end else begin
                                state    <= ST_ERROR;
                                err_code <= ERR_ID;
                                busy     <= 1'b0;
                                init_err <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign wr_ps2         = init_done ? s_wr_ps2  : wr_int;
    assign tx_data        = init_done ? s_tx_data : tx_int;
    assign s_rx_done_tick = rx_done_tick & init_done;

endmodule
